// File: rtl/rx_dma_trans_buf_pkg.sv
// Shared definitions for the RX DMA transaction buffer read side.
package rx_dma_trans_buf_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } rd_state_e;

    // Byte address width for a buffer of buf_bytes bytes.
    function automatic int unsigned addr_w(input int unsigned buf_bytes);
        return 32'($clog2(buf_bytes));
    endfunction

    // Width able to hold a chunk length in the range 1..max_chunk.
    function automatic int unsigned len_w(input int unsigned max_chunk);
        return 32'($clog2(max_chunk)) + 32'd1;
    endfunction

    // Bytes in the next chunk: limited by remaining bytes and room to the boundary.
    function automatic int unsigned chunk_len(input int unsigned rem, input int unsigned room);
        return (rem < room) ? rem : room;
    endfunction

endpackage

// File: rtl/rx_dma_trans_buf_occ_cnt.sv
// Buffer occupancy up/down counter with a registered free-space output.
module rx_dma_trans_buf_occ_cnt
    import rx_dma_trans_buf_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 4096,
    parameter int unsigned MAX_CHUNK = 128,
    parameter int unsigned PKT_LEN_W = 14,
    localparam int unsigned ADDR_W = addr_w(BUF_BYTES),
    localparam int unsigned LEN_W  = len_w(MAX_CHUNK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_vld,
    input  logic [PKT_LEN_W-1:0] inc_len,
    input  logic                 dec_vld,
    input  logic [LEN_W-1:0]     dec_len,
    output logic [ADDR_W:0]      free_space
);

    logic [ADDR_W:0] occ;
    logic [ADDR_W:0] occ_next;
    int unsigned     occ_sum;

    // Apply the accepted packet length and the released chunk length together.
    always_comb begin
        occ_sum = 32'(occ);
        if (inc_vld) begin
            occ_sum = occ_sum + 32'(inc_len);
        end
        if (dec_vld) begin
            occ_sum = occ_sum - 32'(dec_len);
        end
        occ_next = (ADDR_W + 1)'(occ_sum);
    end

    // Occupancy and free space are updated on the same edge, one cycle after the event.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= '0;
            free_space <= (ADDR_W + 1)'(BUF_BYTES);
        end else begin
            occ        <= occ_next;
            free_space <= (ADDR_W + 1)'(BUF_BYTES) - occ_next;
        end
    end

    a_done_when_empty : assert property (@(posedge clk) disable iff (rst)
        !(dec_vld && occ == '0));

    a_occ_underflow : assert property (@(posedge clk) disable iff (rst)
        !dec_vld || (32'(dec_len) <= 32'(occ) + (inc_vld ? 32'(inc_len) : 32'd0)));

endmodule

// File: rtl/rx_dma_trans_buf_rd_ctrl.sv
// Read-side controller: splits buffered packets into boundary-aligned read commands
// and tracks buffer occupancy for the writer.
module rx_dma_trans_buf_rd_ctrl
    import rx_dma_trans_buf_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 4096,
    parameter int unsigned MAX_CHUNK = 128,
    parameter int unsigned PKT_LEN_W = 14,
    localparam int unsigned ADDR_W = addr_w(BUF_BYTES),
    localparam int unsigned LEN_W  = len_w(MAX_CHUNK)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_W-1:0]    PKT_ADDR,
    input  logic [PKT_LEN_W-1:0] PKT_LEN,
    input  logic                 PKT_VLD,
    output logic                 PKT_RDY,
    output logic [ADDR_W-1:0]    RD_ADDR,
    output logic [LEN_W-1:0]     RD_LEN,
    output logic                 RD_SOP,
    output logic                 RD_EOP,
    output logic                 RD_VLD,
    input  logic                 RD_RDY,
    input  logic                 DONE_VLD,
    input  logic [LEN_W-1:0]     DONE_LEN,
    output logic [ADDR_W:0]      FREE_SPACE
);

    rd_state_e            state;
    rd_state_e            state_next;
    logic [PKT_LEN_W-1:0] rem;
    logic                 accept;
    logic                 rd_fire;
    logic                 load;
    logic                 advance;

    int unsigned          src_addr;
    int unsigned          src_rem;
    int unsigned          room;
    int unsigned          len_i;
    logic [ADDR_W-1:0]    nxt_addr;
    logic [PKT_LEN_W-1:0] nxt_rem;
    logic [LEN_W-1:0]     nxt_len;
    logic                 nxt_eop;

    assign accept  = PKT_VLD && PKT_RDY;
    assign rd_fire = RD_VLD && RD_RDY;
    assign RD_VLD  = (state == ST_SPLIT);

    // Next state plus load/advance strobes for the chunk registers.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && PKT_LEN != '0) begin
                    load       = 1'b1;
                    state_next = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (rd_fire) begin
                    if (RD_EOP) begin
                        state_next = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; PKT_RDY is registered so it rises one cycle after EOP or reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            PKT_RDY <= 1'b0;
        end else begin
            state   <= state_next;
            PKT_RDY <= (state_next == ST_IDLE);
        end
    end

    // Next chunk: from the new descriptor when idle, else from the chunk just consumed.
    always_comb begin
        if (state == ST_IDLE) begin
            src_addr = 32'(PKT_ADDR);
            src_rem  = 32'(PKT_LEN);
        end else begin
            src_addr = (32'(RD_ADDR) + 32'(RD_LEN)) % BUF_BYTES;
            src_rem  = 32'(rem) - 32'(RD_LEN);
        end
        room     = MAX_CHUNK - (src_addr % MAX_CHUNK);
        len_i    = chunk_len(src_rem, room);
        nxt_addr = ADDR_W'(src_addr);
        nxt_rem  = PKT_LEN_W'(src_rem);
        nxt_len  = LEN_W'(len_i);
        nxt_eop  = (src_rem <= room);
    end

    // Command registers; held while the consumer stalls. rem includes the current chunk.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_ADDR <= '0;
            RD_LEN  <= '0;
            RD_SOP  <= 1'b0;
            RD_EOP  <= 1'b0;
            rem     <= '0;
        end else if (load || advance) begin
            RD_ADDR <= nxt_addr;
            RD_LEN  <= nxt_len;
            RD_SOP  <= load;
            RD_EOP  <= nxt_eop;
            rem     <= nxt_rem;
        end
    end

    rx_dma_trans_buf_occ_cnt #(
        .BUF_BYTES (BUF_BYTES),
        .MAX_CHUNK (MAX_CHUNK),
        .PKT_LEN_W (PKT_LEN_W)
    ) u_occ_cnt (
        .clk        (CLK),
        .rst        (RST),
        .inc_vld    (accept),
        .inc_len    (PKT_LEN),
        .dec_vld    (DONE_VLD),
        .dec_len    (DONE_LEN),
        .free_space (FREE_SPACE)
    );

    a_occ_overflow : assert property (@(posedge CLK) disable iff (RST)
        !(accept && 32'(PKT_LEN) > 32'(FREE_SPACE)));

endmodule

// File: tb/tb_rx_dma_trans_buf_rd_ctrl.sv
// Directed bench for rx_dma_trans_buf_rd_ctrl with hand-computed expectations.
module tb_rx_dma_trans_buf_rd_ctrl;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pkt_addr;
    logic [13:0]       pkt_len;
    logic              pkt_vld;
    logic              pkt_rdy;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_sop;
    logic              rd_eop;
    logic              rd_vld;
    logic              rd_rdy;
    logic              done_vld;
    logic [LEN_W-1:0]  done_len;
    logic [ADDR_W:0]   free_space;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_dma_trans_buf_rd_ctrl #(
        .BUF_BYTES (4096),
        .MAX_CHUNK (128),
        .PKT_LEN_W (14)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PKT_ADDR   (pkt_addr),
        .PKT_LEN    (pkt_len),
        .PKT_VLD    (pkt_vld),
        .PKT_RDY    (pkt_rdy),
        .RD_ADDR    (rd_addr),
        .RD_LEN     (rd_len),
        .RD_SOP     (rd_sop),
        .RD_EOP     (rd_eop),
        .RD_VLD     (rd_vld),
        .RD_RDY     (rd_rdy),
        .DONE_VLD   (done_vld),
        .DONE_LEN   (done_len),
        .FREE_SPACE (free_space)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_chunk(input string tag, input int unsigned a, input int unsigned l,
                             input logic s, input logic e);
        chk({tag, "_vld"}, 32'(rd_vld), 32'd1);
        chk({tag, "_addr"}, 32'(rd_addr), a);
        chk({tag, "_len"}, 32'(rd_len), l);
        chk({tag, "_sop"}, 32'(rd_sop), 32'(s));
        chk({tag, "_eop"}, 32'(rd_eop), 32'(e));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int unsigned a, input int unsigned l);
        pkt_addr = ADDR_W'(a);
        pkt_len  = 14'(l);
        pkt_vld  = 1'b1;
        step();
        pkt_vld  = 1'b0;
    endtask

    initial begin
        int unsigned exp_a [3];
        int unsigned exp_l [3];
        exp_a[0] = 0;   exp_l[0] = 128;
        exp_a[1] = 128; exp_l[1] = 128;
        exp_a[2] = 256; exp_l[2] = 44;

        rst = 1'b1; pkt_addr = '0; pkt_len = '0; pkt_vld = 1'b0;
        rd_rdy = 1'b0; done_vld = 1'b0; done_len = '0;
        @(negedge clk);
        step();
        chk("rst_pkt_rdy", 32'(pkt_rdy), 32'd0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_sop", 32'(rd_sop), 32'd0);
        chk("rst_eop", 32'(rd_eop), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_len", 32'(rd_len), 32'd0);
        chk("rst_free", 32'(free_space), 32'd4096);
        rst = 1'b0;
        step();
        chk("idle_pkt_rdy", 32'(pkt_rdy), 32'd1);

        // Test 1: aligned 300-byte packet, consumer always ready.
        rd_rdy = 1'b1;
        send(0, 300);
        chk_chunk("t1_c0", 0, 128, 1'b1, 1'b0);
        chk("t1_pkt_rdy", 32'(pkt_rdy), 32'd0);
        chk("t1_free", 32'(free_space), 32'd3796);
        step();
        chk_chunk("t1_c1", 128, 128, 1'b0, 1'b0);
        step();
        chk_chunk("t1_c2", 256, 44, 1'b0, 1'b1);
        step();
        chk("t1_end_vld", 32'(rd_vld), 32'd0);
        chk("t1_end_rdy", 32'(pkt_rdy), 32'd1);

        // Test 2: unaligned start split at the 128 boundary.
        send(100, 60);
        chk_chunk("t2_c0", 100, 28, 1'b1, 1'b0);
        step();
        chk_chunk("t2_c1", 128, 32, 1'b0, 1'b1);
        step();
        chk("t2_end_vld", 32'(rd_vld), 32'd0);
        chk("t2_free", 32'(free_space), 32'd3736);

        // Test 3: address wraps at buffer end.
        send(4090, 20);
        chk_chunk("t3_c0", 4090, 6, 1'b1, 1'b0);
        step();
        chk_chunk("t3_c1", 0, 14, 1'b0, 1'b1);
        step();
        chk("t3_end_vld", 32'(rd_vld), 32'd0);
        chk("t3_free", 32'(free_space), 32'd3716);

        // Test 4: consumer stalls every other cycle.
        rd_rdy = 1'b0;
        send(0, 300);
        for (int i = 0; i < 6; i++) begin
            rd_rdy = (i % 2 == 1);
            chk_chunk("t4_chunk", exp_a[i / 2], exp_l[i / 2], (i / 2 == 0), (i / 2 == 2));
            chk("t4_pkt_rdy", 32'(pkt_rdy), 32'd0);
            step();
        end
        chk("t4_end_vld", 32'(rd_vld), 32'd0);
        chk("t4_end_rdy", 32'(pkt_rdy), 32'd1);
        chk("t4_free", 32'(free_space), 32'd3416);

        // Test 5: release down to occ=200, then accept and release together.
        rd_rdy   = 1'b1;
        done_vld = 1'b1;
        done_len = 8'd128;
        step(); step(); step();
        done_len = 8'd96;
        step();
        done_vld = 1'b0;
        chk("t5_free_200", 32'(free_space), 32'd3896);
        done_vld = 1'b1;
        done_len = 8'd128;
        send(0, 64);
        done_vld = 1'b0;
        chk("t5_free_sim", 32'(free_space), 32'd3960);
        chk_chunk("t5_c0", 0, 64, 1'b1, 1'b1);
        step();
        chk("t5_end_rdy", 32'(pkt_rdy), 32'd1);
        send(0, 0);
        chk("t5_zero_vld", 32'(rd_vld), 32'd0);
        chk("t5_zero_rdy", 32'(pkt_rdy), 32'd1);
        chk("t5_zero_free", 32'(free_space), 32'd3960);
        step();
        chk("t5_zero_vld2", 32'(rd_vld), 32'd0);

        // Test 6: reset during the second chunk.
        send(0, 300);
        chk_chunk("t6_c0", 0, 128, 1'b1, 1'b0);
        step();
        chk_chunk("t6_c1", 128, 128, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_vld", 32'(rd_vld), 32'd0);
        chk("t6_rst_rdy", 32'(pkt_rdy), 32'd0);
        chk("t6_rst_free", 32'(free_space), 32'd4096);
        chk("t6_rst_eop", 32'(rd_eop), 32'd0);
        step();
        chk("t6_post_rdy", 32'(pkt_rdy), 32'd1);
        send(200, 10);
        chk_chunk("t6_new", 200, 10, 1'b1, 1'b1);
        chk("t6_new_free", 32'(free_space), 32'd4086);
        step();
        chk("t6_new_end", 32'(rd_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
